load_store_unit: RTL and testbench

Memory-access stage placed between the EX/MEM pipeline register and the byte-addressed, word-ported `data_memory`. It accepts one load or store per transaction, sequences the memory's registered read and write cycles, and performs read-modify-write for byte and halfword stores. It returns sign- or zero-extended load data and a completion/error response.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage between EX/MEM and a word-ported data memory: sub-word RMW stores and extended loads.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses instead of aligning them down.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_load_i,
  input  logic        req_store_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_read_data_i
);

  // state | meaning
  // IDLE  | ready for a request; error responses issue from here
  // RD    | memory read of the addressed word
  // EXT   | extract/extend the load lane into resp_rdata
  // MRG   | merge store lane into the read word (write buffer)
  // WR    | memory write of the write buffer
  typedef enum logic [2:0] {S_IDLE, S_RD, S_EXT, S_MRG, S_WR} state_e;

  localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        load_q, load_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        req_err;
  logic        misalign;
  logic [31:0] req_addr_al;
  logic [4:0]  lane_sh;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ext_data;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    misalign    = 1'b0;
    req_addr_al = req_addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = (req_size_i == 2'd1 && req_addr_i[0]) ||
               (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);
`else
    if (req_size_i == 2'd1) begin
      req_addr_al[0] = 1'b0;
    end else if (req_size_i == 2'd2) begin
      req_addr_al[1:0] = 2'b00;
    end
`endif
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign accept      = req_valid_i & req_ready_o & (req_load_i | req_store_i);
  assign req_err     = (req_load_i & req_store_i) | (req_size_i == 2'd3) |
                       ({req_addr_i[31:2], 2'b00} >= MemLimit) | misalign;

  always_comb begin
    lane_sh   = {addr_q[1:0], 3'b000};
    lane_half = addr_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_read_data_i[7:0];
      2'd1:    lane_byte = mem_read_data_i[15:8];
      2'd2:    lane_byte = mem_read_data_i[23:16];
      default: lane_byte = mem_read_data_i[31:24];
    endcase
    case (size_q)
      2'd0:    ext_data = {{24{lane_byte[7] & ~uns_q}}, lane_byte};
      2'd1:    ext_data = {{16{lane_half[15] & ~uns_q}}, lane_half};
      default: ext_data = mem_read_data_i;
    endcase
    lane_mask = ((size_q == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    merged    = (mem_read_data_i & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wbuf_d       = wbuf_q;
    rdata_d      = rdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    load_d       = load_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            addr_d  = req_addr_al;
            wdata_d = req_wdata_i;
            size_d  = req_size_i;
            uns_d   = req_unsigned_i;
            load_d  = req_load_i;
            if (req_load_i || req_size_i != 2'd2) begin
              state_d = S_RD;
            end else begin
              wbuf_d  = req_wdata_i;
              state_d = S_WR;
            end
          end
        end
      end
      S_RD:  state_d = load_q ? S_EXT : S_MRG;
      S_EXT: begin
        rdata_d      = ext_data;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_MRG: begin
        wbuf_d  = merged;
        state_d = S_WR;
      end
      S_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wbuf_q       <= '0;
      rdata_q      <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      load_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wbuf_q       <= wbuf_d;
      rdata_q      <= rdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      load_q       <= load_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory strobes come straight from the state register so reset kills them asynchronously.
  assign mem_read_o       = (state_q == S_RD);
  assign mem_write_o      = (state_q == S_WR);
  assign mem_address_o    = {addr_q[31:2], 2'b00};
  assign mem_write_data_o = wbuf_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_err_o       = resp_err_q;
  assign resp_rdata_o     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, directed cases then random traffic.
module tb_load_store_unit;
  localparam int MEM_BYTES = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_load_i, req_store_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o, mem_address_o, mem_write_data_o;
  logic        mem_read_o, mem_write_o;
  logic [31:0] mem_read_data_i;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_load_i(req_load_i), .req_store_i(req_store_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o), .resp_rdata_o(resp_rdata_o),
    .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_read_data_i(mem_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic [31:0] maddr;
    logic [31:0] wword;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [7:0]  tb_mem  [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] last_rdata = '0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Word-ported memory with one-cycle registered read.
  always @(posedge clk_i) begin
    if (mem_read_o)
      mem_read_data_i <= {tb_mem[{mem_address_o[9:2], 2'd3}], tb_mem[{mem_address_o[9:2], 2'd2}],
                          tb_mem[{mem_address_o[9:2], 2'd1}], tb_mem[{mem_address_o[9:2], 2'd0}]};
    if (mem_write_o)
      for (int k = 0; k < 4; k++) tb_mem[{mem_address_o[9:2], 2'(k)}] <= mem_write_data_o[8*k +: 8];
  end

  // Monitor: memory strobes checked against the outstanding entry, responses pop the queue.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read_o || mem_write_o) begin
        if (q.size() == 0) chk("mem_access_unexpected", 32'd1, 32'd0);
        else chk("mem_address", mem_address_o, q[0].maddr);
      end
      if (mem_read_o) rd_cnt++;
      if (mem_write_o) begin
        wr_cnt++;
        if (q.size() != 0) chk("mem_write_data", mem_write_data_o, q[0].wword);
      end
      if (resp_valid_o) begin
        if (q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_err", 32'(resp_err_o), 32'(e.err));
          chk("resp_rdata", resp_rdata_o, e.rdata);
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("read_count", 32'(rd_cnt), 32'(e.nrd));
          chk("write_count", 32'(wr_cnt), 32'(e.nwr));
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic model(input bit ld, input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] w, output exp_t e);
    logic [31:0] ea;
    logic [7:0]  b;
    logic [15:0] h;
    int          idx, base;
    bit          mis;
    ea  = a;
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`else
    if (sz == 2'd1) ea = a & ~32'd1;
    if (sz == 2'd2) ea = a & ~32'd3;
`endif
    e.err   = (ld && st) || sz == 2'd3 || ((a & ~32'd3) >= MEM_BYTES) || mis;
    e.maddr = a & ~32'd3;
    e.wword = '0;
    e.nrd   = 0;
    e.nwr   = 0;
    if (e.err) begin
      e.lat   = 1;
      e.rdata = last_rdata;
      return;
    end
    idx  = int'(ea[9:0]);
    base = idx & ~3;
    if (ld) begin
      b = ref_mem[idx];
      h = {ref_mem[idx + 1], ref_mem[idx]};
      if (sz == 2'd0) e.rdata = un ? 32'(b) : 32'($signed(b));
      else if (sz == 2'd1) e.rdata = un ? 32'(h) : 32'($signed(h));
      else e.rdata = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      last_rdata = e.rdata;
      e.lat = 3;
      e.nrd = 1;
    end else begin
      for (int k = 0; k < (1 << sz); k++) ref_mem[idx + k] = w[8*k +: 8];
      e.wword = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      e.rdata = last_rdata;
      e.lat   = (sz == 2'd2) ? 2 : 4;
      e.nrd   = (sz == 2'd2) ? 0 : 1;
      e.nwr   = 1;
    end
  endtask

  task automatic drive(input bit ld, input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] w);
    req_valid_i    = 1'b1;
    req_load_i     = ld;
    req_store_i    = st;
    req_size_i     = sz;
    req_unsigned_i = un;
    req_addr_i     = a;
    req_wdata_i    = w;
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!req_ready_o && g < 50) begin
      @(negedge clk_i);
      g++;
    end
    if (g == 50) chk("ready_timeout", 32'(req_ready_o), 32'd1);
  endtask

  task automatic issue(input bit ld, input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] w);
    exp_t e;
    @(negedge clk_i);
    drive(ld, st, sz, un, a, w);
    wait_ready();
    if (ld || st) begin
      model(ld, st, sz, un, a, w, e);
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk_i);
      g++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_mid_store();
    exp_t e;
    drain();
    @(negedge clk_i);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_00AA);
    wait_ready();
    e.err = 1'b0; e.rdata = '0; e.lat = 4; e.acc = cyc;
    e.maddr = 32'h40; e.wword = 32'h4342_41AA; e.nrd = 1; e.nwr = 1;
    q.push_back(e);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("rst_mem_write", 32'(mem_write_o), 32'd0);
    chk("rst_mem_read", 32'(mem_read_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    q.delete();
    last_rdata = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      chk("post_rst_mem_write", 32'(mem_write_o), 32'd0);
      chk("post_rst_ready", 32'(req_ready_o), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) begin
      tb_mem[i]  = 8'(i);
      ref_mem[i] = 8'(i);
    end
    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_load_i = 1'b0; req_store_i = 1'b0;
    req_size_i = 2'd0; req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    #2;
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("reset_resp_err", 32'(resp_err_o), 32'd0);
    chk("reset_rdata", resp_rdata_o, 32'd0);
    chk("reset_mem_read", 32'(mem_read_o), 32'd0);
    chk("reset_mem_write", 32'(mem_write_o), 32'd0);
    chk("reset_mem_address", mem_address_o, 32'd0);
    chk("reset_mem_wdata", mem_write_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    issue(1, 0, 2'd2, 0, 32'h10, 32'h0);
    issue(1, 0, 2'd0, 0, 32'h83, 32'h0);
    issue(1, 0, 2'd0, 1, 32'h83, 32'h0);
    issue(1, 0, 2'd1, 0, 32'h82, 32'h0);
    issue(0, 1, 2'd1, 0, 32'h22, 32'h1234_BEEF);
    issue(1, 0, 2'd2, 0, 32'h20, 32'h0);
    issue(1, 0, 2'd1, 0, 32'h21, 32'h0);
    issue(0, 1, 2'd2, 0, 32'h400, 32'hDEAD_BEEF);
    issue(1, 1, 2'd2, 0, 32'h10, 32'h0);
    issue(1, 0, 2'd3, 0, 32'h10, 32'h0);
    issue(0, 0, 2'd2, 0, 32'h10, 32'h0);
    issue(1, 0, 2'd2, 0, 32'h3FC, 32'h0);
    issue(0, 1, 2'd2, 0, 32'h3FF, 32'h0BAD_F00D);
    reset_mid_store();
    issue(1, 0, 2'd2, 0, 32'h40, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = $urandom_range(0, 15);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 19) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1100));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      issue(r >= 2 && r <= 8, r == 1 || r > 8 || r == 1, sz, 1'($urandom_range(0, 1)),
            a, 32'($urandom));
      if (r == 1) issue(1, 1, sz, 0, a, 32'h0);
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
